// File: rtl/duty_ramp_ctrl_pkg.sv
// Shared types and constants for the duty ramp sequencer.
// No logic here; state encoding and default sizing only.
package duty_ramp_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAMP_UP   = 2'd1,
        ST_RAMP_DOWN = 2'd2,
        ST_STOP      = 2'd3
    } ramp_state_t;

    localparam logic [1:0] DUTY_MAX            = 2'd3;
    localparam int         DEF_PWM_PERIOD_CLKS = 100000;
    localparam int         DEF_STEP_PERIODS    = 50;

    function automatic logic is_ramp(input ramp_state_t s);
        return (s == ST_RAMP_UP) || (s == ST_RAMP_DOWN);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for slow asynchronous inputs (switches), any width.
// Latency: 2 clocks. No backpressure; samples every clock.
// Bits are synchronised independently; multi-bit inputs may briefly show mixed old/new values.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clock_50mhz,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            meta <= '0;
            dout <= '0;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/duty_ramp_ctrl.sv
// Soft-start/stop sequencer stepping a 2-bit PWM duty select toward a switch target on PWM period boundaries.
// Latency: target seen 3 clocks after change, steps every STEP_PERIODS periods; estop forces duty 0 on the next edge.
// No backpressure. Optional DUTY_RAMP_FAST_DOWN_EN: ramp-down loads the target in one edge instead of stepping.
module duty_ramp_ctrl
    import duty_ramp_ctrl_pkg::*;
#(
    parameter int PWM_PERIOD_CLKS = DEF_PWM_PERIOD_CLKS,
    parameter int STEP_PERIODS    = DEF_STEP_PERIODS
) (
    input  logic       clock_50mhz,
    input  logic       reset,
    input  logic [1:0] target_duty,
    input  logic       enable,
    input  logic       estop,
    output logic [1:0] duty_cycle,
    output logic       period_tick,
    output logic       ramping,
    output logic       at_target
);

    localparam int PW = (PWM_PERIOD_CLKS > 1) ? $clog2(PWM_PERIOD_CLKS) : 1;
    localparam int SW = (STEP_PERIODS > 1) ? $clog2(STEP_PERIODS) : 1;

    logic [1:0]    sync_target;
    logic [1:0]    eff_target;
    logic [PW-1:0] period_cnt;
    logic [PW-1:0] period_cnt_nxt;
    logic [SW-1:0] step_cnt;
    logic [SW-1:0] step_cnt_adv;
    logic [SW-1:0] step_cnt_nxt;
    logic          step_event;
    ramp_state_t   state;
    ramp_state_t   state_nxt;
    logic [1:0]    duty_nxt;

    sync_2ff #(.WIDTH(2)) u_sync_target (
        .clock_50mhz (clock_50mhz),
        .reset       (reset),
        .din         (target_duty),
        .dout        (sync_target)
    );

    assign eff_target = enable ? sync_target : 2'd0;

    // Free-running period counter; the tick is registered so it lines up with the last count.
    always_comb begin
        period_cnt_nxt = period_cnt + 1'b1;
        if (period_cnt == PW'(PWM_PERIOD_CLKS - 1)) begin
            period_cnt_nxt = '0;
        end
    end

    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            period_cnt  <= '0;
            period_tick <= 1'b0;
        end else begin
            period_cnt  <= period_cnt_nxt;
            period_tick <= (period_cnt_nxt == PW'(PWM_PERIOD_CLKS - 1));
        end
    end

    assign step_event   = period_tick && (step_cnt == SW'(STEP_PERIODS - 1));
    assign step_cnt_adv = step_event  ? '0 :
                          period_tick ? step_cnt + 1'b1 : step_cnt;

    always_comb begin
        state_nxt    = state;
        duty_nxt     = duty_cycle;
        step_cnt_nxt = step_cnt_adv;
        if (estop) begin
            state_nxt    = ST_STOP;
            duty_nxt     = 2'd0;
            step_cnt_nxt = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    step_cnt_nxt = '0;
                    if (eff_target > duty_cycle) begin
                        state_nxt = ST_RAMP_UP;
                    end else if (eff_target < duty_cycle) begin
`ifdef DUTY_RAMP_FAST_DOWN_EN
                        duty_nxt  = eff_target;
`else
                        state_nxt = ST_RAMP_DOWN;
`endif
                    end
                end
                ST_RAMP_UP: begin
                    if (eff_target < duty_cycle) begin
                        step_cnt_nxt = '0;
`ifdef DUTY_RAMP_FAST_DOWN_EN
                        duty_nxt     = eff_target;
                        state_nxt    = ST_IDLE;
`else
                        state_nxt    = ST_RAMP_DOWN;
`endif
                    end else if (eff_target == duty_cycle) begin
                        state_nxt    = ST_IDLE;
                        step_cnt_nxt = '0;
                    end else if (step_event && duty_cycle != DUTY_MAX) begin
                        duty_nxt = duty_cycle + 2'd1;
                        if (duty_cycle + 2'd1 == eff_target) begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                ST_RAMP_DOWN: begin
                    if (eff_target > duty_cycle) begin
                        state_nxt    = ST_RAMP_UP;
                        step_cnt_nxt = '0;
                    end else if (eff_target == duty_cycle) begin
                        state_nxt    = ST_IDLE;
                        step_cnt_nxt = '0;
                    end else if (step_event && duty_cycle != 2'd0) begin
                        duty_nxt = duty_cycle - 2'd1;
                        if (duty_cycle - 2'd1 == eff_target) begin
                            state_nxt = ST_IDLE;
                        end
                    end
                end
                default: begin
                    state_nxt    = ST_IDLE;
                    step_cnt_nxt = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock_50mhz) begin
        if (reset) begin
            state      <= ST_IDLE;
            duty_cycle <= 2'd0;
            step_cnt   <= '0;
            ramping    <= 1'b0;
            at_target  <= 1'b1;
        end else begin
            state      <= state_nxt;
            duty_cycle <= duty_nxt;
            step_cnt   <= step_cnt_nxt;
            ramping    <= is_ramp(state_nxt);
            at_target  <= (duty_nxt == eff_target) && (state_nxt != ST_STOP);
        end
    end

endmodule

// File: tb/tb_duty_ramp_ctrl.sv
// Directed bench for duty_ramp_ctrl with PWM_PERIOD_CLKS=10, STEP_PERIODS=2.
// Edge numbers count rising edges since the last reset release.
module tb_duty_ramp_ctrl;

    logic       clock_50mhz = 1'b0;
    logic       reset       = 1'b1;
    logic [1:0] target_duty = 2'd0;
    logic       enable      = 1'b1;
    logic       estop       = 1'b0;
    logic [1:0] duty_cycle;
    logic       period_tick;
    logic       ramping;
    logic       at_target;

    int checks = 0;
    int errors = 0;
    int edges  = 0;

    duty_ramp_ctrl #(
        .PWM_PERIOD_CLKS (10),
        .STEP_PERIODS    (2)
    ) u_dut (
        .clock_50mhz (clock_50mhz),
        .reset       (reset),
        .target_duty (target_duty),
        .enable      (enable),
        .estop       (estop),
        .duty_cycle  (duty_cycle),
        .period_tick (period_tick),
        .ramping     (ramping),
        .at_target   (at_target)
    );

    always #10 clock_50mhz = ~clock_50mhz;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s edge=%0d got=%0d expected=%0d", tag, edges, got, exp);
        end
    endtask

    // Advance to just after rising edge n.
    task automatic run_to(input int n);
        while (edges < n) begin
            @(posedge clock_50mhz);
            edges++;
        end
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_duty"},   int'(duty_cycle),  0);
        chk({tag, "_tick"},   int'(period_tick), 0);
        chk({tag, "_ramp"},   int'(ramping),     0);
        chk({tag, "_attgt"},  int'(at_target),   1);
    endtask

    initial begin
        target_duty = 2'd3;
        repeat (3) @(posedge clock_50mhz);
        #1;
        chk_reset_vals("rst");
        reset = 1'b0;
        edges = 0;

        // Soft start 0 -> 3
        run_to(3);
        chk("up_ramping", int'(ramping), 1);
        chk("up_attgt",   int'(at_target), 0);
        run_to(8);
        chk("tick_lo8",   int'(period_tick), 0);
        run_to(9);
        chk("tick_hi9",   int'(period_tick), 1);
        run_to(10);
        chk("tick_lo10",  int'(period_tick), 0);
        run_to(19);
        chk("up_d0_19",   int'(duty_cycle), 0);
        run_to(20);
        chk("up_d1_20",   int'(duty_cycle), 1);
        run_to(40);
        chk("up_d2_40",   int'(duty_cycle), 2);
        run_to(59);
        chk("up_d2_59",   int'(duty_cycle), 2);
        run_to(60);
        chk("up_d3_60",   int'(duty_cycle), 3);
        chk("up_done_ramp",  int'(ramping), 0);
        chk("up_done_attgt", int'(at_target), 1);

        // Ramp down 3 -> 0
        target_duty = 2'd0;
`ifdef DUTY_RAMP_FAST_DOWN_EN
        run_to(63);
        chk("fdn_d0_63",  int'(duty_cycle), 0);
        chk("fdn_ramp",   int'(ramping), 0);
`else
        run_to(63);
        chk("dn_ramping", int'(ramping), 1);
        run_to(79);
        chk("dn_d3_79",   int'(duty_cycle), 3);
        run_to(80);
        chk("dn_d2_80",   int'(duty_cycle), 2);
        run_to(100);
        chk("dn_d1_100",  int'(duty_cycle), 1);
`endif
        run_to(120);
        chk("dn_d0_120",  int'(duty_cycle), 0);
        chk("dn_attgt",   int'(at_target), 1);
        chk("dn_ramp",    int'(ramping), 0);

        // Reverse mid ramp-up at duty 1
        target_duty = 2'd3;
        run_to(140);
        chk("rev_d1_140", int'(duty_cycle), 1);
        target_duty = 2'd0;
`ifdef DUTY_RAMP_FAST_DOWN_EN
        run_to(143);
        chk("rev_fast_d0", int'(duty_cycle), 0);
`else
        run_to(150);
        chk("rev_d1_150", int'(duty_cycle), 1);
        chk("rev_ramping", int'(ramping), 1);
`endif
        run_to(160);
        chk("rev_d0_160", int'(duty_cycle), 0);
        chk("rev_ramp160", int'(ramping), 0);

        // Emergency stop at duty 2 while ramping to 3
        target_duty = 2'd3;
        run_to(200);
        chk("es_d2_200",  int'(duty_cycle), 2);
        chk("es_ramp200", int'(ramping), 1);
        run_to(205);
        estop = 1'b1;
        run_to(206);
        chk("es_duty",    int'(duty_cycle), 0);
        chk("es_ramp",    int'(ramping), 0);
        chk("es_attgt",   int'(at_target), 0);
        estop = 1'b0;
        target_duty = 2'd2;
        run_to(209);
        chk("es_tick209", int'(period_tick), 1);
        run_to(219);
        chk("es_d0_219",  int'(duty_cycle), 0);
        run_to(220);
        chk("es_d1_220",  int'(duty_cycle), 1);
        run_to(240);
        chk("es_d2_240",  int'(duty_cycle), 2);
        chk("es_attgt240", int'(at_target), 1);

        // Disable ramps down from 3, then reset mid-ramp
        target_duty = 2'd3;
        run_to(260);
        chk("en_d3_260",  int'(duty_cycle), 3);
        enable = 1'b0;
`ifdef DUTY_RAMP_FAST_DOWN_EN
        run_to(261);
        chk("en_fast_d0", int'(duty_cycle), 0);
`else
        run_to(261);
        chk("en_ramping", int'(ramping), 1);
        chk("en_attgt",   int'(at_target), 0);
        run_to(280);
        chk("en_d2_280",  int'(duty_cycle), 2);
`endif
        run_to(285);
        reset = 1'b1;
        run_to(286);
        chk_reset_vals("mid_rst");
        reset = 1'b0;
        edges = 0;
        run_to(8);
        chk("rr_tick8",   int'(period_tick), 0);
        run_to(9);
        chk("rr_tick9",   int'(period_tick), 1);
        chk("rr_duty",    int'(duty_cycle), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
